vga_color_sfr: RTL

//  Memory-mapped responder for the CPU's color_config SFR plus a 640x480@60 VGA timing generator.

---
 rtl/vga_color_sfr.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vga_color_sfr.sv
// color_config SFR responder plus a 640x480@60 VGA timing generator painting every visible pixel.
// Optional macro VGA_FRAME_SYNC_EN: the displayed color only changes at a frame wrap (no tearing).
module vga_color_sfr #(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] SFR_ADDR = 8'd0,
    parameter int         H_VIS    = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_VIS    = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_write,
    output logic [11:0] color_q,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_VIS_E  = HW'(H_VIS);
    localparam logic [HW-1:0]    H_SYNC_S = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0]    H_SYNC_E = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_VIS_E  = VW'(V_VIS);
    localparam logic [VW-1:0]    V_SYNC_S = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0]    V_SYNC_E = VW'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [11:0]      color_config;
    logic [11:0]      act_color;
    logic [11:0]      rgb_q;
    logic             pix_ce;
    logic             out_ce;
    logic             sfr_hit;
    logic             h_wrap;
    logic             wrap;
    logic             visible;
    logic             hs_n;
    logic             vs_n;
    logic             unused_wdata_hi;

    assign unused_wdata_hi = ^mem_wdata[15:12];

    assign sfr_hit = mem_write && (mem_addr == SFR_ADDR);
    assign pix_ce  = (div_cnt == DIV_LAST);
    assign h_wrap  = pix_ce && (h_cnt == H_LAST);
    assign wrap    = h_wrap && (v_cnt == V_LAST);

    assign visible = (h_cnt < H_VIS_E) && (v_cnt < V_VIS_E);
    assign hs_n    = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
    assign vs_n    = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
            if (pix_ce)
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            color_config <= 12'h000;
        else if (sfr_hit)
            color_config <= mem_wdata[11:0];
    end

`ifdef VGA_FRAME_SYNC_EN
    // A store landing on the wrap clock must be the one the new frame shows.
    always_ff @(posedge clk) begin
        if (rst)
            act_color <= 12'h000;
        else if (wrap)
            act_color <= sfr_hit ? mem_wdata[11:0] : color_config;
    end
`else
    assign act_color = color_config;
`endif

    // out_ce is the clk after each counter step, so the first pixel after reset loads too.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ce      <= 1'b1;
            rgb_q       <= 12'h000;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            out_ce      <= pix_ce;
            frame_start <= wrap;
            if (out_ce) begin
                rgb_q <= visible ? act_color : 12'h000;
                hsync <= hs_n;
                vsync <= vs_n;
            end
        end
    end

    assign color_q = color_config;
    assign vga_r   = rgb_q[3:0];
    assign vga_g   = rgb_q[7:4];
    assign vga_b   = rgb_q[11:8];

endmodule
